// File: rtl/p1v_serial_rx.sv
// 8N1 UART receiver for the Propeller pin-30 serial output, oversampled at CLKS_PER_BIT.
// Build option: define P1V_RX_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise a single holding register.
`timescale 1ns/1ps

module p1v_serial_rx #(
    parameter int CLKS_PER_BIT = 1389,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clock_160,
    input  logic       reset,
    input  logic       rx_line,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy,
    output logic [2:0] dbg_state_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    generate
        if (CLKS_PER_BIT < 16 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
            $error("p1v_serial_rx: CLKS_PER_BIT out of range 16..65535");
        end
        if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
            $error("p1v_serial_rx: FIFO_DEPTH must be a power of two in 2..256");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic          meta_q, sync_q, prev_q;
    logic          armed_q, armed_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          frame_err_q, overrun_q;
    logic          fall, cnt_zero, push, bad_stop;
    logic          pop, full, accept, overrun_d;

    assign fall     = prev_q & ~sync_q;
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clock_160) begin
        if (reset) begin
            meta_q      <= 1'b0;
            sync_q      <= 1'b0;
            prev_q      <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            meta_q      <= rx_line;
            sync_q      <= meta_q;
            prev_q      <= sync_q;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= bad_stop;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        push     = 1'b0;
        bad_stop = 1'b0;
        armed_d  = armed_q | sync_q;
        case (state_q)
            S_IDLE: begin
                if (fall && armed_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            S_START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (!sync_q) begin
                    state_d = S_DATA;
                    cnt_d   = FULL_LOAD;
                    idx_d   = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    shift_d[idx_q] = sync_q;
                    cnt_d          = FULL_LOAD;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (sync_q) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    // A low stop bit usually means a break; re-arm only once the line returns high.
                    bad_stop = 1'b1;
                    armed_d  = 1'b0;
                    state_d  = S_BREAK;
                end
            end
            S_BREAK: begin
                if (sync_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output handshake: rx_data is held while rx_valid && !rx_ready; a byte is consumed
    // on every rising edge with rx_valid && rx_ready, and the next entry shows one cycle later.
    assign pop       = rx_valid & rx_ready;
    assign accept    = push & (~full | pop);
    assign overrun_d = push & full & ~pop;

`ifdef P1V_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]  mem_q [FIFO_DEPTH];

    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rx_valid = (wr_ptr_q != rd_ptr_q);
    assign rx_data  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clock_160) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
                wr_ptr_q                <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end
`else
    logic [7:0] hold_q;
    logic       hold_valid_q;

    assign full     = hold_valid_q;
    assign rx_valid = hold_valid_q;
    assign rx_data  = hold_q;

    always_ff @(posedge clock_160) begin
        if (reset) begin
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
        end else if (accept) begin
            hold_q       <= shift_q;
            hold_valid_q <= 1'b1;
        end else if (pop) begin
            hold_valid_q <= 1'b0;
        end
    end
`endif

    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_p1v_serial_rx.sv
// Directed plus randomized bench for p1v_serial_rx at 16 clocks per bit; works with or without P1V_RX_FIFO_EN.
`timescale 1ns/1ps

module tb_p1v_serial_rx;
  localparam int CPB = 16;
`ifdef P1V_RX_FIFO_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_line;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [2:0] dbg_state;

  p1v_serial_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
    .clock_160   (clk),
    .reset       (reset),
    .rx_line     (rx_line),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         both_cnt = 0;
  int         rise_cyc = -2;
  int         start_cyc = 0;
  bit         saw_busy = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] rcv_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // observer: sampled on the falling edge, where everything is settled
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) rcv_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && overrun) both_cnt++;
      if (busy) saw_busy = 1;
      if (rx_valid && !prev_valid && rise_cyc == -1) rise_cyc = cyc;
    end
    prev_valid = rx_valid;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) tick();
  endtask

  // pulse_at >= 0 drives rx_ready high only during that bit-clock of the frame
  task automatic send_byte(input logic [7:0] b, input bit stop_hi, input int pulse_at);
    logic [9:0] frame;
    frame = {stop_hi, b, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      rx_line = frame[i / CPB];
      if (i == 0) start_cyc = cyc;
      if (pulse_at >= 0) rx_ready = (i == pulse_at);
      tick();
    end
    rx_line = 1'b1;
  endtask

  task automatic wait_rcv(input int n);
    int t;
    t = 0;
    while (rcv_q.size() < n && t < 400) begin
      tick();
      t++;
    end
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    chk({tag, "_count"}, rcv_q.size(), exp_q.size());
    while (exp_q.size() > 0 && rcv_q.size() > 0) begin
      chk({tag, "_byte"}, rcv_q.pop_front(), exp_q.pop_front());
    end
    exp_q.delete();
    rcv_q.delete();
  endtask

  initial begin
    int t;
    int lat;
    int t1_start;
    int fe0;
    int ov0;
    logic [7:0] b;

    // reset with the line held low: no start may be accepted afterwards
    reset = 1'b1;
    rx_line = 1'b0;
    rx_ready = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    repeat (40) tick();
    chk("held_low_busy", saw_busy, 0);
    idle(40);

    // T1 basic two bytes
    rx_ready = 1'b1;
    rise_cyc = -1;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, -1);
    t1_start = start_cyc;
    idle($urandom_range(1, 20));
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, -1);
    wait_rcv(2);
    lat = rise_cyc - t1_start;
    checks++;
    assert (lat >= 152 && lat <= 157) else begin
      failures++;
      $error("FAIL t1_latency observed=%0d expected=152..157", lat);
    end
    sb_check("t1");
    chk("t1_frame_err", fe_cnt, 0);
    chk("t1_overrun", ov_cnt, 0);

    // T2 glitch
    idle(20);
    saw_busy = 0;
    rx_line = 1'b0;
    repeat (4) tick();
    rx_line = 1'b1;
    t = 0;
    while (busy && t < 12) begin
      tick();
      t++;
    end
    chk("t2_saw_busy", saw_busy, 1);
    chk("t2_busy_dropped", busy, 0);
    chk("t2_drop_in_8", (t <= 8), 1);
    idle(40);
    sb_check("t2");
    chk("t2_frame_err", fe_cnt, 0);

    // T3 framing error, then a good byte
    fe0 = fe_cnt;
    send_byte(8'h55, 1'b0, -1);
    idle(2 * CPB);
    exp_q.push_back(8'h0F);
    send_byte(8'h0F, 1'b1, -1);
    wait_rcv(1);
    chk("t3_frame_err", fe_cnt - fe0, 1);
    sb_check("t3");

    // T4 overrun: DEPTH+1 bytes with nobody reading
    idle(20);
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    for (int k = 0; k <= DEPTH; k++) begin
      send_byte(8'(k), 1'b1, -1);
      if (k < DEPTH) exp_q.push_back(8'(k));
      idle($urandom_range(2, 10));
    end
    chk("t4_overrun", ov_cnt - ov0, 1);
    chk("t4_valid_held", rx_valid, 1);
    chk("t4_data_held", rx_data, 8'h00);
    chk("t4_nothing_popped", rcv_q.size(), 0);
    rx_ready = 1'b1;
    wait_rcv(DEPTH);
    idle(10);
    sb_check("t4");

    // T5 pop coinciding with a push into a full buffer
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    for (int k = 0; k < DEPTH; k++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_byte(b, 1'b1, -1);
      idle($urandom_range(2, 10));
    end
    b = 8'($urandom);
    exp_q.push_back(b);
    send_byte(b, 1'b1, 154);
    idle(4);
    chk("t5_no_overrun", ov_cnt - ov0, 0);
    chk("t5_one_popped", rcv_q.size(), 1);
    chk("t5_valid", rx_valid, 1);
    send_byte(8'($urandom), 1'b1, -1);
    idle(4);
    chk("t5_still_full", ov_cnt - ov0, 1);
    rx_ready = 1'b1;
    wait_rcv(DEPTH + 1);
    idle(10);
    sb_check("t5");

    // T6 reset in the middle of data bit 4 of 8'hFF
    idle(20);
    for (int i = 0; i < 88; i++) begin
      rx_line = (i < CPB) ? 1'b0 : 1'b1;
      tick();
    end
    chk("t6_busy_before", busy, 1);
    reset = 1'b1;
    rx_line = 1'b0;
    tick();
    chk("t6_rst_valid", rx_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_data", rx_data, 8'h00);
    tick();
    reset = 1'b0;
    saw_busy = 0;
    repeat (40) tick();
    chk("t6_low_ignored", saw_busy, 0);
    idle(2 * CPB);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1, -1);
    wait_rcv(1);
    sb_check("t6");

    // T7 random bytes with random consumer stalls between frames
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(1, 30)) begin
        rx_ready = 1'($urandom_range(0, 1));
        idle(1);
      end
      rx_ready = 1'b1;
      idle(2);
      b = 8'($urandom);
      exp_q.push_back(b);
      send_byte(b, 1'b1, -1);
    end
    wait_rcv(8);
    sb_check("t7");
    chk("t7_frame_err", fe_cnt - fe0, 0);
    chk("t7_overrun", ov_cnt - ov0, 0);
    chk("never_both_pulses", both_cnt, 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
